// File: rtl/next_pc_unit.sv
// next_pc_unit: program-counter sequencer with conditional branch, call,
// return, sticky halt, registered flush pulse and an optional hardware
// return-address stack (enabled by defining NEXT_PC_RAS_EN).
module next_pc_unit #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             halt,
  input  logic [2:0]                       cond,
  input  logic                             z,
  input  logic                             v,
  input  logic                             n,
  input  logic [PC_W-1:0]                  b_imm,
  input  logic [PC_W-1:0]                  c_imm,
  input  logic [PC_W-1:0]                  ret_reg,
  output logic [PC_W-1:0]                  pc,
  output logic                             flush,
  output logic                             halted,
  output logic                             ras_miss,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_d;
  logic [PC_W-1:0]   seq;
  logic              flush_d;
  logic              halted_d;
  logic              taken;

`ifdef NEXT_PC_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  wp_inc;
  logic [PTR_W-1:0]  top_idx;
  logic [CNT_W-1:0]  cnt_d;
  logic              miss_d;
  logic              push;

  // Circular pointer arithmetic; wp_q is the next slot to write, top is newest
  always_comb begin
    wp_inc  = (wp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
    top_idx = (wp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : wp_q - PTR_W'(1);
  end
`endif

  // Branch condition evaluation from the flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000:  taken = !z;
      3'b001:  taken = z;
      3'b010:  taken = !n && !z;
      3'b011:  taken = n;
      3'b100:  taken = z || (!n && !z);
      3'b101:  taken = n || z;
      3'b110:  taken = v;
      default: taken = 1'b1;
    endcase
  end

  // Next-state / next-pc resolution with branch > call > ret > halt priority
  always_comb begin
    state_d  = state_q;
    pc_d     = pc;
    flush_d  = 1'b0;
    halted_d = halted;
    seq      = pc + PC_W'(1);
`ifdef NEXT_PC_RAS_EN
    wp_d     = wp_q;
    cnt_d    = ras_count;
    miss_d   = 1'b0;
    push     = 1'b0;
`endif
    if (state_q == RUN && !stall) begin
      if (branch) begin
        if (taken) begin
          pc_d    = seq + b_imm;
          flush_d = 1'b1;
        end else begin
          pc_d = seq;
        end
      end else if (call) begin
        pc_d    = seq + c_imm;
        flush_d = 1'b1;
`ifdef NEXT_PC_RAS_EN
        push    = 1'b1;
        wp_d    = wp_inc;
        if (ras_count != CNT_W'(RAS_DEPTH)) cnt_d = ras_count + CNT_W'(1);
`endif
      end else if (ret) begin
        flush_d = 1'b1;
`ifdef NEXT_PC_RAS_EN
        if (ras_count != '0) begin
          pc_d  = ras_mem[top_idx];
          wp_d  = top_idx;
          cnt_d = ras_count - CNT_W'(1);
        end else begin
          pc_d   = ret_reg;
          miss_d = 1'b1;
        end
`else
        pc_d    = ret_reg;
`endif
      end else if (halt) begin
        state_d  = HALTED;
        halted_d = 1'b1;
      end else begin
        pc_d = seq;
      end
    end
  end

  // State, pc and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc        <= PC_W'(RESET_PC);
      flush     <= 1'b0;
      halted    <= 1'b0;
`ifdef NEXT_PC_RAS_EN
      wp_q      <= '0;
      ras_count <= '0;
      ras_miss  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      flush     <= flush_d;
      halted    <= halted_d;
`ifdef NEXT_PC_RAS_EN
      wp_q      <= wp_d;
      ras_count <= cnt_d;
      ras_miss  <= miss_d;
`endif
    end
  end

`ifdef NEXT_PC_RAS_EN
  // Return-address storage; contents are don't-care once ras_count is cleared
  always_ff @(posedge clk) begin
    if (!rst && push) ras_mem[wp_q] <= seq;
  end
`else
  assign ras_count = '0;
  assign ras_miss  = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios plus random
// stimulus compared against a queue-based behavioural model.
module tb_next_pc_unit;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned RESET_PC  = 0;
  localparam int unsigned CNT_W     = $clog2(RAS_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, stall, branch, call, ret, halt;
  logic [2:0]        cond;
  logic              z, v, n;
  logic [PC_W-1:0]   b_imm, c_imm, ret_reg;
  logic [PC_W-1:0]   pc;
  logic              flush, halted, ras_miss;
  logic [CNT_W-1:0]  ras_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [PC_W-1:0]   m_pc;
  bit                m_halted, m_flush, m_miss;
  logic [PC_W-1:0]   m_ras[$];

  next_pc_unit #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .call(call),
    .ret(ret), .halt(halt), .cond(cond), .z(z), .v(v), .n(n),
    .b_imm(b_imm), .c_imm(c_imm), .ret_reg(ret_reg), .pc(pc),
    .flush(flush), .halted(halted), .ras_miss(ras_miss), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_true(input logic [2:0] c, input bit fz, input bit fv, input bit fn);
    case (c)
      3'd0: return !fz;
      3'd1: return fz;
      3'd2: return !fn && !fz;
      3'd3: return fn;
      3'd4: return fz || (!fn && !fz);
      3'd5: return fn || fz;
      3'd6: return fv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic set_idle();
    rst = 0; stall = 0; branch = 0; call = 0; ret = 0; halt = 0;
    cond = 3'd0; z = 0; v = 0; n = 0;
    b_imm = '0; c_imm = '0; ret_reg = '0;
  endtask

  // Advance the model by one edge with the currently driven inputs, clock, compare
  task automatic step(input string tag);
    logic [PC_W-1:0] s;
    bit f, mi;
    f = 0; mi = 0;
    if (rst) begin
      m_pc = PC_W'(RESET_PC); m_halted = 0;
      m_ras.delete();
    end else if (!m_halted && !stall) begin
      s = m_pc + PC_W'(1);
      if (branch) begin
        if (cond_true(cond, z, v, n)) begin m_pc = s + b_imm; f = 1; end
        else m_pc = s;
      end else if (call) begin
        m_pc = s + c_imm; f = 1;
`ifdef NEXT_PC_RAS_EN
        m_ras.push_back(s);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
`endif
      end else if (ret) begin
        f = 1;
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin
          m_pc = ret_reg;
`ifdef NEXT_PC_RAS_EN
          mi = 1;
`endif
        end
      end else if (halt) begin
        m_halted = 1;
      end else begin
        m_pc = s;
      end
    end
    m_flush = f; m_miss = mi;
    @(posedge clk); #1;
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".flush"}, 32'(flush), 32'(m_flush));
    check({tag, ".halted"}, 32'(halted), 32'(m_halted));
    check({tag, ".ras_miss"}, 32'(ras_miss), 32'(m_miss));
    check({tag, ".ras_count"}, 32'(ras_count), 32'(m_ras.size()));
  endtask

  task automatic jump_to(input logic [PC_W-1:0] t);
    set_idle();
    branch = 1; cond = 3'd7; b_imm = t - (m_pc + PC_W'(1));
    step("jump");
    set_idle();
  endtask

  logic [PC_W-1:0] rets [5];
  int unsigned exp_cnt;

  initial begin
    m_pc = '0; m_halted = 0; m_flush = 0; m_miss = 0;
    set_idle();
    rst = 1;
    step("reset0");
    step("reset1");
    check("reset_pc", 32'(pc), 32'(RESET_PC));
    set_idle();

    // Idle sequencing
    for (int i = 1; i <= 3; i++) begin
      step("idle");
      check("idle_pc", 32'(pc), 32'(i));
      check("idle_flush", 32'(flush), 32'd0);
    end

    // NE branch taken with negative offset, then not taken
    jump_to(16'h0010);
    branch = 1; cond = 3'd0; z = 0; b_imm = 16'hFFFC;
    step("br_ne_t");
    check("br_ne_t_pc", 32'(pc), 32'h000D);
    check("br_ne_t_flush", 32'(flush), 32'd1);
    set_idle();
    step("after_br");
    check("flush_one_cycle", 32'(flush), 32'd0);
    jump_to(16'h0010);
    branch = 1; cond = 3'd0; z = 1; b_imm = 16'hFFFC;
    step("br_ne_nt");
    check("br_ne_nt_pc", 32'(pc), 32'h0011);
    check("br_ne_nt_flush", 32'(flush), 32'd0);

    // Call then return
    jump_to(16'h0020);
    call = 1; c_imm = 16'h0100;
    step("call");
    check("call_pc", 32'(pc), 32'h0121);
    set_idle();
    ret = 1; ret_reg = 16'hBEEF;
    step("ret");
`ifdef NEXT_PC_RAS_EN
    check("ret_pc", 32'(pc), 32'h0021);
`else
    check("ret_pc", 32'(pc), 32'hBEEF);
`endif
    check("ret_cnt", 32'(ras_count), 32'd0);

    // Five nested calls, five returns
    for (int i = 0; i < 5; i++) begin
      set_idle();
      rets[i] = m_pc + PC_W'(1);
      call = 1; c_imm = PC_W'(16'h0040 * (i + 1));
      step("ncall");
    end
`ifdef NEXT_PC_RAS_EN
    exp_cnt = RAS_DEPTH;
`else
    exp_cnt = 0;
`endif
    check("ras_sat", 32'(ras_count), 32'(exp_cnt));
    for (int i = 0; i < 5; i++) begin
      set_idle();
      ret = 1; ret_reg = 16'h7A00 + PC_W'(i);
      step("nret");
`ifdef NEXT_PC_RAS_EN
      if (i < 4) begin
        check("nret_pc", 32'(pc), 32'(rets[4-i]));
        check("nret_miss", 32'(ras_miss), 32'd0);
      end else begin
        check("nret_pc", 32'(pc), 32'(16'h7A04));
        check("nret_miss", 32'(ras_miss), 32'd1);
      end
`else
      check("nret_pc", 32'(pc), 32'(16'h7A00 + PC_W'(i)));
`endif
    end

    // Halt is sticky until reset
    jump_to(16'h0030);
    halt = 1;
    step("halt");
    check("halt_pc", 32'(pc), 32'h0030);
    check("halt_flag", 32'(halted), 32'd1);
    set_idle();
    branch = 1; cond = 3'd7; b_imm = 16'h0100;
    step("halt_br");
    set_idle();
    call = 1; c_imm = 16'h0100;
    step("halt_call");
    check("halt_hold_pc", 32'(pc), 32'h0030);
    check("halt_hold_flush", 32'(flush), 32'd0);
    set_idle();
    rst = 1;
    step("halt_rst");
    check("rst_pc", 32'(pc), 32'(RESET_PC));
    check("rst_halted", 32'(halted), 32'd0);
    set_idle();

    // Stall blocks a taken branch, which then takes effect
    jump_to(16'h0040);
    stall = 1; branch = 1; cond = 3'd7; b_imm = 16'h0010;
    step("stall");
    check("stall_pc", 32'(pc), 32'h0040);
    check("stall_flush", 32'(flush), 32'd0);
    stall = 0;
    step("unstall");
    check("unstall_pc", 32'(pc), 32'h0051);

    // Branch beats call; no push
    set_idle();
    branch = 1; cond = 3'd7; b_imm = 16'h0005; call = 1; c_imm = 16'h0200;
    step("br_call");
    check("br_call_pc", 32'(pc), 32'h0057);
    check("br_call_cnt", 32'(ras_count), 32'd0);

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      branch  = ($urandom_range(0, 3) == 0);
      call    = ($urandom_range(0, 3) == 0);
      ret     = ($urandom_range(0, 3) == 0);
      halt    = ($urandom_range(0, 31) == 0);
      cond    = 3'($urandom);
      z       = 1'($urandom); v = 1'($urandom); n = 1'($urandom);
      b_imm   = PC_W'($urandom);
      c_imm   = PC_W'($urandom);
      ret_reg = PC_W'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
